// File: rtl/uut_result_packer.sv
// Measures hash-core latency from release to end_signal, then streams the
// captured hash and cycle count as a big-endian byte record over valid/ready.
module uut_result_packer #(
  parameter int HASH_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  end_signal_i,
  input  logic [HASH_WIDTH-1:0] hash_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam int N_BYTES = HASH_WIDTH / 8 + CNT_WIDTH / 8;
  localparam int REC_W   = N_BYTES * 8;
  localparam int IDX_W   = $clog2(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic [1:0] {IDLE, COUNT, SEND, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [REC_W-1:0]     rec_q, rec_d;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     idx_inc;

  // Byte 0 of the record is the most significant byte of the latched word.
  logic [7:0] rec_bytes [N_BYTES];
  generate
    for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_rec_bytes
      assign rec_bytes[gi] = rec_q[REC_W-1-gi*8 -: 8];
    end
  endgenerate

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    rec_d   = rec_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (start_i) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (end_signal_i) begin
          // First byte is loaded at the capture edge so valid rises next cycle.
          rec_d   = {hash_i, cnt_q};
          idx_d   = '0;
          byte_d  = hash_i[HASH_WIDTH-1 -: 8];
          valid_d = 1'b1;
          state_d = SEND;
        end else if (&cnt_q) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (valid_q && byte_ready_i) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            byte_d  = 8'h00;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d  = idx_inc;
            byte_d = rec_bytes[idx_inc];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      rec_q   <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      rec_q   <= rec_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_uut_result_packer.sv
// Directed bench for uut_result_packer: a default instance plus an 8-bit
// counter instance for saturation, both fed from the same stimulus.
module tb_uut_result_packer;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic         end_signal_i;
  logic [127:0] hash_i;
  logic         byte_ready_i;
  logic [7:0]   byte_o, b8_byte;
  logic         byte_valid_o, b8_valid;
  logic         busy_o, b8_busy;
  logic         done_o, b8_done;
  logic         overflow_o, b8_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] H1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] H2 = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
  localparam logic [127:0] H3 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  uut_result_packer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .end_signal_i(end_signal_i),
    .hash_i(hash_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o)
  );

  uut_result_packer #(.HASH_WIDTH(128), .CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start_i), .end_signal_i(end_signal_i),
    .hash_i(hash_i), .byte_o(b8_byte), .byte_valid_o(b8_valid),
    .byte_ready_i(byte_ready_i), .busy_o(b8_busy), .done_o(b8_done),
    .overflow_o(b8_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_meas(input int k, input logic [127:0] h);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_rise", {31'b0, busy_o}, 32'd1);
    repeat (k - 1) @(negedge clk);
    hash_i       = h;
    end_signal_i = 1'b1;
  endtask

  // mode 0: ready high; 1: random ready with a 7-cycle stall on byte 15;
  // 2: ready high, start pulse and hash change while sending byte 3.
  task automatic collect(input int sel, input int nb, input logic [159:0] exp,
                         input int mode, input int stop, input string tag);
    int   got, cyc, dones, st15;
    bit   holding, rdy;
    logic v, d;
    logic [7:0] b, held;
    got = 0; cyc = 0; dones = 0; st15 = 0; holding = 0; held = 8'h00;
    while (got < stop && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0;
      v = sel ? b8_valid : byte_valid_o;
      b = sel ? b8_byte  : byte_o;
      d = sel ? b8_done  : done_o;
      if (d) dones++;
      if (holding) begin
        chk({tag, "_stall_valid"}, {31'b0, v}, 32'd1);
        chk({tag, "_stall_byte"}, {24'b0, b}, {24'b0, held});
      end
      rdy = 1'b1;
      if (mode == 1) begin
        if (v && got == 15 && st15 < 7) begin
          rdy = 1'b0;
          st15++;
        end else begin
          rdy = ($urandom_range(0, 1) == 1);
        end
      end
      if (mode == 2 && v && got == 3) begin
        start_i = 1'b1;
        hash_i  = ~hash_i;
      end
      byte_ready_i = rdy;
      if (v && rdy) begin
        chk($sformatf("%s_byte%0d", tag, got), {24'b0, b}, {24'b0, exp[(nb-1-got)*8 +: 8]});
        got++;
        holding = 0;
      end else if (v) begin
        holding = 1;
        held    = b;
      end
    end
    chk({tag, "_bytes_seen"}, got, stop);
    chk({tag, "_no_early_done"}, dones, 32'd0);
    if (stop == nb) begin
      @(negedge clk);
      byte_ready_i = 1'b1;
      chk({tag, "_done_pulse"}, {31'b0, sel ? b8_done : done_o}, 32'd1);
      chk({tag, "_valid_off"}, {31'b0, sel ? b8_valid : byte_valid_o}, 32'd0);
      @(negedge clk);
      chk({tag, "_done_clear"}, {31'b0, sel ? b8_done : done_o}, 32'd0);
      chk({tag, "_busy_fall"}, {31'b0, sel ? b8_busy : busy_o}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; end_signal_i = 1'b0;
    hash_i = '0; byte_ready_i = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("rst_byte",  {24'b0, byte_o}, 32'd0);
    chk("rst_valid", {31'b0, byte_valid_o}, 32'd0);
    chk("rst_busy",  {31'b0, busy_o}, 32'd0);
    chk("rst_done",  {31'b0, done_o}, 32'd0);
    chk("rst_ovf",   {31'b0, overflow_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic record: end seen at 5th COUNT edge -> count 4.
    start_meas(5, H1);
    collect(0, 20, {H1, 32'd4}, 0, 20, "basic");
    chk("basic_ovf", {31'b0, overflow_o}, 32'd0);
    end_signal_i = 1'b0;

    start_meas(5, H1);
    collect(0, 20, {H1, 32'd4}, 1, 20, "bp");
    end_signal_i = 1'b0;
    byte_ready_i = 1'b1;
    repeat (3) @(negedge clk);

    // end_signal high in IDLE must not produce a record.
    hash_i = H2;
    end_signal_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_end_valid", {31'b0, byte_valid_o}, 32'd0);
    chk("idle_end_busy",  {31'b0, busy_o}, 32'd0);
    start_meas(1, H2);
    collect(0, 20, {H2, 32'd0}, 0, 20, "imm");
    end_signal_i = 1'b0;

    start_meas(3, H3);
    collect(0, 20, {H3, 32'd2}, 2, 20, "ign");
    chk("ign_idle", {31'b0, busy_o}, 32'd0);
    end_signal_i = 1'b0;
    repeat (2) @(negedge clk);

    // Saturation on the 8-bit counter instance.
    start_meas(301, H1);
    chk("sat_ovf_set", {31'b0, b8_ovf}, 32'd1);
    chk("main_no_ovf", {31'b0, overflow_o}, 32'd0);
    collect(1, 17, {24'h0, H1, 8'hFF}, 0, 17, "sat");
    for (int i = 0; i < 50 && busy_o; i++) @(negedge clk);
    chk("sat_main_idle", {31'b0, busy_o}, 32'd0);
    chk("sat_ovf_hold", {31'b0, b8_ovf}, 32'd1);
    end_signal_i = 1'b0;

    // Reset after byte 7 has transferred.
    start_meas(4, H1);
    chk("sat_ovf_clear", {31'b0, b8_ovf}, 32'd0);
    collect(0, 20, {H1, 32'd3}, 0, 8, "pre_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_byte",  {24'b0, byte_o}, 32'd0);
    chk("mid_rst_valid", {31'b0, byte_valid_o}, 32'd0);
    chk("mid_rst_busy",  {31'b0, busy_o}, 32'd0);
    chk("mid_rst_done",  {31'b0, done_o}, 32'd0);
    chk("mid_rst_ovf",   {31'b0, overflow_o}, 32'd0);
    @(negedge clk);
    end_signal_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_held_valid", {31'b0, byte_valid_o}, 32'd0);
    rst = 1'b1;
    start_meas(2, H1);
    collect(0, 20, {H1, 32'd1}, 0, 20, "fresh");
    end_signal_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
